// File: rtl/dpll_nco.sv
// Numerically controlled oscillator for the DPLL data separator.
// A phase accumulator advances by freq_word = freq_nom + freq_off each enabled
// cycle; its carry is the bit-cell strobe and its top half is the cell phase.
// freq_off is loaded from the clamped loop-filter correction. When corrections
// stop arriving, holdover starts and the offset decays towards zero.
//
// Input handshake: phase_adj is sampled only on a cycle where phase_adj_valid
// and enable are both high; there is no back-pressure, so every valid pulse is
// consumed on the edge it is presented. rate_change is a single-cycle pulse
// that is always consumed, with or without enable.
module dpll_nco #(
    parameter int ACC_W       = 32,
    parameter int ADJ_SHIFT   = 12,
    parameter int RANGE_SHIFT = 3,
    parameter int HOLD_CELLS  = 64,
    parameter int DECAY_CELLS = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [ACC_W-1:0]  freq_nom,
    input  logic              rate_change,
    input  logic [15:0]       phase_adj,
    input  logic              phase_adj_valid,
    output logic              cell_strobe,
    output logic [15:0]       cell_phase,
    output logic [ACC_W-1:0]  freq_word,
    output logic              clamp_active,
    output logic              adj_hold
);

    localparam int HC_W = $clog2(HOLD_CELLS + 1);
    localparam int DC_W = $clog2(DECAY_CELLS + 1);
    localparam logic [HC_W-1:0] HOLD_MAX   = HC_W'(HOLD_CELLS);
    localparam logic [HC_W-1:0] HOLD_LAST  = HC_W'(HOLD_CELLS - 1);
    localparam logic [DC_W-1:0] DECAY_LAST = DC_W'(DECAY_CELLS - 1);

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic signed [ACC_W-1:0] freq_off_q, freq_off_d;
    logic [ACC_W-1:0]        freq_word_q, freq_word_d;
    logic                    strobe_q, strobe_d;
    logic                    clamp_q, clamp_d;
    logic                    hold_q, hold_d;
    logic [HC_W-1:0]         hold_cnt_q, hold_cnt_d;
    logic [DC_W-1:0]         decay_cnt_q, decay_cnt_d;

    // Correction scaling and clamping, compared as signed 33-bit values so the
    // unsigned limit never wraps into the sign bit.
    logic signed [ACC_W-1:0] adj_ext;
    logic signed [ACC_W-1:0] raw;
    logic signed [ACC_W:0]   raw_x;
    logic signed [ACC_W:0]   lim_x;
    logic signed [ACC_W:0]   neg_lim_x;
    logic signed [ACC_W:0]   clamped_x;
    logic                    clamp_hit;
    logic signed [ACC_W-1:0] decayed;
    logic [ACC_W:0]          sum;

    // Scale, clamp and decay arithmetic feeding the state update.
    always_comb begin
        adj_ext   = ACC_W'(signed'(phase_adj));
        raw       = adj_ext <<< ADJ_SHIFT;
        raw_x     = {raw[ACC_W-1], raw};
        lim_x     = {1'b0, freq_nom >> RANGE_SHIFT};
        neg_lim_x = -lim_x;
        clamped_x = raw_x;
        clamp_hit = 1'b0;
        if (raw_x > lim_x) begin
            clamped_x = lim_x;
            clamp_hit = 1'b1;
        end else if (raw_x < neg_lim_x) begin
            clamped_x = neg_lim_x;
            clamp_hit = 1'b1;
        end
        // -1 >>> 1 stays -1, so force it to zero to let the decay finish.
        if (freq_off_q == -1) decayed = '0;
        else                  decayed = freq_off_q >>> 1;
        sum = {1'b0, acc_q} + {1'b0, freq_word_q};
    end

    // Next-state selection: rate change first, then enabled advance with
    // correction load or holdover bookkeeping.
    always_comb begin
        acc_d       = acc_q;
        freq_off_d  = freq_off_q;
        freq_word_d = freq_nom + $unsigned(freq_off_q);
        strobe_d    = 1'b0;
        clamp_d     = clamp_q;
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
        decay_cnt_d = decay_cnt_q;
        if (rate_change) begin
            acc_d       = {1'b1, {(ACC_W-1){1'b0}}};
            freq_off_d  = '0;
            freq_word_d = freq_nom;
            clamp_d     = 1'b0;
            hold_d      = 1'b0;
            hold_cnt_d  = '0;
            decay_cnt_d = '0;
        end else if (enable) begin
            acc_d    = sum[ACC_W-1:0];
            strobe_d = sum[ACC_W];
            if (phase_adj_valid) begin
                freq_off_d  = clamped_x[ACC_W-1:0];
                clamp_d     = clamp_hit;
                hold_d      = 1'b0;
                hold_cnt_d  = '0;
                decay_cnt_d = '0;
            end else if (sum[ACC_W]) begin
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) hold_d = 1'b1;
                end
                if (hold_q) begin
                    if (decay_cnt_q == DECAY_LAST) begin
                        decay_cnt_d = '0;
                        freq_off_d  = decayed;
                    end else begin
                        decay_cnt_d = decay_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            freq_off_q  <= '0;
            freq_word_q <= '0;
            strobe_q    <= 1'b0;
            clamp_q     <= 1'b0;
            hold_q      <= 1'b0;
            hold_cnt_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            freq_off_q  <= freq_off_d;
            freq_word_q <= freq_word_d;
            strobe_q    <= strobe_d;
            clamp_q     <= clamp_d;
            hold_q      <= hold_d;
            hold_cnt_q  <= hold_cnt_d;
            decay_cnt_q <= decay_cnt_d;
        end
    end

    assign cell_strobe  = strobe_q;
    assign cell_phase   = acc_q[ACC_W-1:ACC_W-16];
    assign freq_word    = freq_word_q;
    assign clamp_active = clamp_q;
    assign adj_hold     = hold_q;

endmodule

// File: tb/tb_dpll_nco.sv
// Directed bench for dpll_nco: correction/clamp vector table plus hand-written
// sequences for period, holdover decay, priority and asynchronous reset.
module tb_dpll_nco;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] freq_nom;
    logic        rate_change;
    logic [15:0] phase_adj;
    logic        phase_adj_valid;
    logic        cell_strobe;
    logic [15:0] cell_phase;
    logic [31:0] freq_word;
    logic        clamp_active;
    logic        adj_hold;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [15:0] adj;
        logic [31:0] exp_word;
        logic        exp_clamp;
    } vec_t;

    vec_t vecs[8];

    dpll_nco dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .freq_nom        (freq_nom),
        .rate_change     (rate_change),
        .phase_adj       (phase_adj),
        .phase_adj_valid (phase_adj_valid),
        .cell_strobe     (cell_strobe),
        .cell_phase      (cell_phase),
        .freq_word       (freq_word),
        .clamp_active    (clamp_active),
        .adj_hold        (adj_hold)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Returns the number of edges until a strobe is seen, or -1 on timeout.
    task automatic wait_strobe(input int budget, output int n);
        bit found;
        found = 0;
        n = 0;
        while (n < budget && !found) begin
            step();
            n++;
            if (cell_strobe) found = 1;
        end
        if (!found) n = -1;
    endtask

    task automatic apply_adj(input logic [15:0] v);
        phase_adj       = v;
        phase_adj_valid = 1'b1;
        step();
        phase_adj_valid = 1'b0;
    endtask

    task automatic wait_word(input logic [31:0] target, input int budget);
        int n;
        n = 0;
        while (freq_word !== target && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n31;
        logic [15:0] cp;

        vecs[0] = '{"adj_0100", 16'h0100, 32'h0810_0000, 1'b0};
        vecs[1] = '{"adj_7fff", 16'h7FFF, 32'h0900_0000, 1'b1};
        vecs[2] = '{"adj_8000", 16'h8000, 32'h0700_0000, 1'b1};
        vecs[3] = '{"adj_ffff", 16'hFFFF, 32'h07FF_F000, 1'b0};
        vecs[4] = '{"adj_pos_lim", 16'h1000, 32'h0900_0000, 1'b0};
        vecs[5] = '{"adj_pos_over", 16'h1001, 32'h0900_0000, 1'b1};
        vecs[6] = '{"adj_neg_lim", 16'hF000, 32'h0700_0000, 1'b0};
        vecs[7] = '{"adj_zero", 16'h0000, 32'h0800_0000, 1'b0};

        // Clock / reset
        reset_n         = 1'b0;
        enable          = 1'b0;
        freq_nom        = 32'h0;
        rate_change     = 1'b0;
        phase_adj       = 16'h0;
        phase_adj_valid = 1'b0;
        repeat (3) step();
        chk("rst_phase", cell_phase, 16'h0);
        chk("rst_word", freq_word, 32'h0);
        chk("rst_strobe", cell_strobe, 1'b0);
        chk("rst_clamp", clamp_active, 1'b0);
        chk("rst_hold", adj_hold, 1'b0);
        reset_n = 1'b1;
        step();

        // Period check
        freq_nom    = 32'h0800_0000;
        enable      = 1'b1;
        rate_change = 1'b1;
        step();
        rate_change = 1'b0;
        chk("rc_phase", cell_phase, 16'h8000);
        chk("rc_word", freq_word, 32'h0800_0000);
        chk("rc_strobe", cell_strobe, 1'b0);
        step();
        chk("phase_step", cell_phase, 16'h8800);
        wait_strobe(100, n);
        chk("first_strobe", n, 15);
        chk("wrap_phase", cell_phase, 16'h0000);
        wait_strobe(100, n);
        chk("period_nom", n, 32);

        // Correction and clamp vectors
        for (int i = 0; i < 8; i++) begin
            apply_adj(vecs[i].adj);
            step();
            chk({vecs[i].name, "_word"}, freq_word, vecs[i].exp_word);
            chk({vecs[i].name, "_clamp"}, clamp_active, vecs[i].exp_clamp);
        end

        // Corrected period: 31 or 32 cycles, with 31 appearing
        apply_adj(16'h0100);
        step();
        wait_strobe(100, n);
        n31 = 0;
        for (int i = 0; i < 8; i++) begin
            wait_strobe(100, n);
            if (n == 31) n31++;
            chk("corr_period_ok", (n == 31 || n == 32), 1'b1);
        end
        chk("corr_period_has31", (n31 > 0), 1'b1);

        // Disabled: accumulator frozen, valid ignored
        enable = 1'b0;
        cp = cell_phase;
        repeat (5) begin
            step();
            chk("dis_strobe", cell_strobe, 1'b0);
        end
        chk("dis_phase", cell_phase, cp);
        apply_adj(16'h7FFF);
        step();
        chk("dis_word", freq_word, 32'h0810_0000);
        enable = 1'b1;

        // Holdover from positive offset
        apply_adj(16'h0100);
        for (int k = 1; k <= 64; k++) begin
            wait_strobe(40, n);
            if (n < 0) chk("hold_strobe_timeout", n, 32'd0);
            if (k == 63) chk("hold_before", adj_hold, 1'b0);
            if (k == 64) chk("hold_rise", adj_hold, 1'b1);
        end
        for (int k = 1; k <= 15; k++) wait_strobe(40, n);
        chk("decay_not_yet", freq_word, 32'h0810_0000);
        wait_strobe(40, n);
        step();
        chk("decay_half", freq_word, 32'h0808_0000);
        wait_word(32'h0800_0000, 20000);
        chk("decay_zero_pos", freq_word, 32'h0800_0000);
        chk("hold_still", adj_hold, 1'b1);

        // Negative offset: exit holdover immediately, decay past -1
        apply_adj(16'hFFFF);
        chk("hold_exit", adj_hold, 1'b0);
        step();
        chk("neg_word", freq_word, 32'h07FF_F000);
        wait_word(32'h0800_0000, 20000);
        chk("decay_zero_neg", freq_word, 32'h0800_0000);

        // Priority: rate_change beats phase_adj_valid
        apply_adj(16'h7FFF);
        step();
        chk("pre_prio_clamp", clamp_active, 1'b1);
        freq_nom        = 32'h0400_0000;
        rate_change     = 1'b1;
        phase_adj       = 16'h0100;
        phase_adj_valid = 1'b1;
        step();
        rate_change     = 1'b0;
        phase_adj_valid = 1'b0;
        chk("prio_word", freq_word, 32'h0400_0000);
        chk("prio_phase", cell_phase, 16'h8000);
        chk("prio_strobe", cell_strobe, 1'b0);
        chk("prio_clamp", clamp_active, 1'b0);
        chk("prio_hold", adj_hold, 1'b0);
        step();
        chk("prio_word_next", freq_word, 32'h0400_0000);

        // Asynchronous reset mid-cell
        apply_adj(16'h7FFF);
        step();
        chk("pre_rst_clamp", clamp_active, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_phase", cell_phase, 16'h0);
        chk("arst_word", freq_word, 32'h0);
        chk("arst_strobe", cell_strobe, 1'b0);
        chk("arst_clamp", clamp_active, 1'b0);
        chk("arst_hold", adj_hold, 1'b0);
        freq_nom = 32'h0800_0000;
        #2;
        reset_n = 1'b1;
        wait_strobe(60, n);
        chk("post_rst_strobe", n, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
